// File: rtl/hilo_md_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller: op and state
// encodings, divider constants and the single restoring-divide step.
package md_defs;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } md_state_e;

    localparam int MD_DIV_ITER = 32;
    localparam int MD_RES_W    = 64;

    typedef struct packed {
        logic [31:0] rem;
        logic [31:0] quo;
    } div_step_t;

    // quo shifts dividend bits out of its MSB while quotient bits enter at its LSB.
    function automatic div_step_t div_step(input logic [31:0] rem,
                                           input logic [31:0] quo,
                                           input logic [31:0] dvs);
        logic [32:0] sh;
        logic [32:0] diff;
        div_step_t   r;
        sh    = {rem, quo[31]};
        diff  = sh - {1'b0, dvs};
        r.quo = {quo[30:0], ~diff[32]};
        r.rem = diff[32] ? sh[31:0] : diff[31:0];
        return r;
    endfunction

endpackage

// File: rtl/hilo_md_ctrl_if.sv
// EX-stage <-> multiply/divide controller bus: operation request, HI/LO moves,
// flush, and the stall/done/HI/LO returns.
interface hilo_md_ctrl_if;
    import md_defs::*;

    logic        start;
    md_op_e      op;
    logic [31:0] num1;
    logic [31:0] num2;
    logic        flush;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    modport master (
        output start, op, num1, num2, flush, mthi_we, mtlo_we, wdata,
        input  busy, done, hi_o, lo_o
    );

    modport slave (
        input  start, op, num1, num2, flush, mthi_we, mtlo_we, wdata,
        output busy, done, hi_o, lo_o
    );

endinterface

// File: rtl/hilo_md_ctrl_div_core.sv
// Iterative unsigned restoring divider, one quotient bit per clock. The load
// cycle already performs the first iteration, so ITER edges yield ITER bits.
module div_core_radix2 import md_defs::*; #(
    parameter int ITER = MD_DIV_ITER
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        flush_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    output logic [31:0] quotient_o,
    output logic [31:0] remainder_o,
    output logic        valid_o
);

    localparam int            CW   = $clog2(ITER + 1);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    logic [31:0]   rem_q;
    logic [31:0]   quo_q;
    logic [31:0]   dvs_q;
    logic [CW-1:0] cnt_q;
    logic          run_q;
    div_step_t     step;

    always_comb begin
        if (start_i) step = div_step('0, dividend_i, divisor_i);
        else         step = div_step(rem_q, quo_q, dvs_q);
    end

    // Outputs are the final step's combinational result, consumed on the last edge.
    assign quotient_o  = step.quo;
    assign remainder_o = step.rem;
    assign valid_o     = run_q && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            run_q <= 1'b1;
            cnt_q <= CW'(1);
        end else if (run_q) begin
            run_q <= !valid_o;
            cnt_q <= valid_o ? '0 : cnt_q + 1'b1;
        end
    end

    // NOTE: datapath registers carry no reset; run_q alone decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (start_i || run_q) begin
            rem_q <= step.rem;
            quo_q <= step.quo;
        end
        if (start_i) dvs_q <= divisor_i;
    end

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO multiply/divide sequencer with stall, MTHI/MTLO and flush handling.
// Optional MD_DIV_ZERO_FAST_EN: divide by zero completes on the accept edge.
module hilo_md_ctrl import md_defs::*; #(
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = MD_DIV_ITER
) (
    input logic           clk,
    input logic           rst,
    hilo_md_ctrl_if.slave md_if
);

    localparam int               CNT_W      = $clog2(MUL_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LAST   = CNT_W'(MUL_LAT - 1);
    localparam bit               MUL_DIRECT = (MUL_LAT == 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    md_op_e           op_q;
    logic [31:0]      a_q, b_q;

    logic              idle_like, accept, div_start, div_zero_fast, div_valid;
    logic [31:0]       dvd_mag, dvs_mag, div_quo, div_rem, quo_fix, rem_fix;
    logic [31:0]       mul_a, mul_b;
    logic              mul_signed, div_signed;
    logic [MD_RES_W-1:0] product;

    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept    = md_if.start && idle_like && !md_if.flush;

`ifdef MD_DIV_ZERO_FAST_EN
    assign div_zero_fast = (md_if.num2 == '0);
`else
    assign div_zero_fast = 1'b0;
`endif

    assign div_start = accept && md_if.op[1] && !div_zero_fast;
    assign dvd_mag   = (md_if.op == MD_DIV && md_if.num1[31]) ? -md_if.num1 : md_if.num1;
    assign dvs_mag   = (md_if.op == MD_DIV && md_if.num2[31]) ? -md_if.num2 : md_if.num2;

    div_core_radix2 #(.ITER(DIV_ITER)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start_i    (div_start),
        .flush_i    (md_if.flush),
        .dividend_i (dvd_mag),
        .divisor_i  (dvs_mag),
        .quotient_o (div_quo),
        .remainder_o(div_rem),
        .valid_o    (div_valid)
    );

    // Sign-extending both operands makes one 64-bit multiply serve MULT and MULTU.
    assign mul_signed = MUL_DIRECT ? (md_if.op == MD_MULT) : (op_q == MD_MULT);
    assign mul_a      = MUL_DIRECT ? md_if.num1 : a_q;
    assign mul_b      = MUL_DIRECT ? md_if.num2 : b_q;
    assign product    = {{32{mul_signed & mul_a[31]}}, mul_a} * {{32{mul_signed & mul_b[31]}}, mul_b};

    assign div_signed = (op_q == MD_DIV);
    assign quo_fix    = (div_signed && (a_q[31] ^ b_q[31])) ? -div_quo : div_quo;
    assign rem_fix    = (div_signed && a_q[31]) ? -div_rem : div_rem;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        // Moves are older than anything flushed and land before a same-edge result overwrite.
        if (idle_like) begin
            if (md_if.mthi_we) hi_d = md_if.wdata;
            if (md_if.mtlo_we) lo_d = md_if.wdata;
        end
        if (md_if.flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_d = ST_IDLE;
                    if (accept) begin
                        cnt_d = '0;
                        if (!md_if.op[1]) begin
                            if (MUL_DIRECT) begin
                                {hi_d, lo_d} = product;
                                state_d      = ST_DONE;
                            end else begin
                                state_d = ST_MUL;
                            end
                        end else if (div_zero_fast) begin
                            hi_d    = md_if.num1;
                            lo_d    = '1;
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DIV;
                        end
                    end
                end
                ST_MUL: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == MUL_LAST) begin
                        {hi_d, lo_d} = product;
                        state_d      = ST_DONE;
                    end
                end
                ST_DIV: begin
                    if (div_valid) begin
                        state_d = ST_DONE;
                        hi_d    = (b_q == '0) ? a_q : rem_fix;
                        lo_d    = (b_q == '0) ? '1  : quo_fix;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_q <= md_if.op;
            a_q  <= md_if.num1;
            b_q  <= md_if.num2;
        end
    end

    assign md_if.busy = (state_q == ST_MUL) || (state_q == ST_DIV) || accept;
    assign md_if.done = (state_q == ST_DONE);
    assign md_if.hi_o = hi_q;
    assign md_if.lo_o = lo_q;

endmodule

// File: doc/hilo_md_ctrl.md
Name: hilo_md_ctrl

Overview:
- Sequences the multiply/divide resource beside the ALU. Accepts MULT/MULTU/DIV/DIVU from EX, runs a fixed-latency multiply or an iterative radix-2 divide, and owns the HI/LO register pair.
- Drives the pipeline stall while an operation is in flight. Also services MTHI/MTLO writes and cancels work on exception flush.

Parameters:
- MUL_LAT, 2, cycles from accept to HI/LO write for multiply (min 1).
- DIV_ITER, 32, divider iterations (one quotient bit per cycle); fixed at 32 for 32-bit operands.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  EX holds a mult/div instruction; level, held while stalled
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- num1  in  32  rs operand (dividend / multiplicand)
- num2  in  32  rt operand (divisor / multiplier)
- flush  in  1  exception/eret flush of EX and later stages
- mthi_we  in  1  write wdata to HI
- mtlo_we  in  1  write wdata to LO
- wdata  in  32  MTHI/MTLO data
- busy  out  1  combinational stall request to the hazard unit
- done  out  1  one-cycle pulse; HI/LO hold the new result this cycle
- hi_o  out  32  HI register
- lo_o  out  32  LO register

Behaviour:
- Reset (rst=1 at an edge): state IDLE, counters 0, hi_o=0, lo_o=0, done=0. busy=0 once rst deasserts.
- States: IDLE, MUL, DIV, DONE.
- IDLE/DONE with start=1 and flush=0: latch op, num1, num2. Go to MUL (op[1]=0) or DIV (op[1]=1) and clear the counter.
- busy = (state==MUL || state==DIV) || (start && (state==IDLE || state==DONE) && !flush). busy is 0 in DONE unless a new start is accepted.
- MUL:
  - Counter increments each cycle. Product is computed from the latched operands: signed 32x32->64 for MULT, unsigned for MULTU.
  - At the edge where the counter reaches MUL_LAT-1: HI=product[63:32], LO=product[31:0], state goes to DONE.
  - Total latency is MUL_LAT cycles from the accept edge to the HI/LO update.
- DIV:
  - Operands are converted to magnitudes on accept (DIV only; DIVU uses them raw).
  - Restoring shift-subtract produces one quotient bit per cycle. The sign fix is applied on the final (DIV_ITER-th) edge, together with the HI/LO write.
  - Quotient is negative iff the operand signs differ. Remainder takes the sign of the dividend.
  - LO=quotient, HI=remainder.
  - Example: DIV -7/2 gives LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero (num2==0), both DIV and DIVU: HI=num1, LO=0xFFFFFFFF. Latency is DIV_ITER cycles unless the optional feature is enabled.
- DIV corner: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wrap, no trap).
- DONE: done=1 for exactly one cycle. The next state is IDLE, or MUL/DIV if start is accepted again (back-to-back).
- MTHI/MTLO:
  - Take effect at the edge when state is IDLE or DONE.
  - Ignored in MUL/DIV (the hazard unit holds them behind busy).
  - Both may assert in the same cycle.
  - MTHI/MTLO in DONE with a concurrent start: the move writes first. The new operation later overwrites HI/LO.
- Flush:
  - Flush in any state: next state is IDLE, counters cleared, no HI/LO write, no done pulse.
  - Flush with start in the same cycle: flush wins; nothing is accepted.
  - Flush does not block a concurrent mthi_we/mtlo_we in IDLE (that instruction is older).
- Reset mid-operation: identical to flush, plus HI/LO are cleared.
- Operand changes after the accept edge have no effect; only latched values are used.

Optional Feature:
- Macro MD_DIV_ZERO_FAST_EN.
- Defined: divide by zero goes from accept directly to DONE with the HI/LO write at the next edge (1-cycle latency). busy is asserted only during the accept cycle.
- Undefined: divide by zero runs the full DIV_ITER cycles. Results are identical in both builds.

Decomposition:
- Shared package md_defs:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU
  - state encoding (IDLE/MUL/DIV/DONE)
  - DIV_ITER constant
  - result-width constant (64)
- Sub-module div_core_radix2: iterative unsigned restoring divider.
  - Inputs: start, dividend, divisor, flush. Outputs: quotient, remainder, valid.
  - The controller does the sign conversion and the zero-divisor override.

Test Plan:
- MULT 0xFFFFFFFE * 0x00000003 -> after 2 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA, one done pulse, busy high exactly 2 cycles.
- MULTU 0xFFFFFFFF * 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV -7/2 -> 32 cycles busy, LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 -> LO=14, HI=2.
- DIVU 5/0 -> HI=5, LO=0xFFFFFFFF. Latency 32 cycles without MD_DIV_ZERO_FAST_EN, 1 cycle with it.
- DIV started, flush at cycle 10 with HI=0x11, LO=0x22 preloaded via MTHI/MTLO -> IDLE next cycle, HI/LO unchanged, no done, busy drops.
- Back-to-back: MULT done cycle with start=1 for DIVU 9/4 -> accepted with no idle gap. mthi_we in IDLE with wdata=0xABCD -> hi_o=0xABCD next cycle. rst mid-DIV -> HI=LO=0.
